// File: rtl/tq_enq_responder_pkg.sv
// Shared swarm types used by the task-queue enqueue responder, plus the
// pending-entry layout private to the responder.
package tq_enq_responder_pkg;

  typedef logic [3:0] tsb_entry_id_t;
  typedef logic [7:0] epoch_t;
  typedef logic [5:0] tq_slot_t;

  typedef struct packed {
    logic [7:0]  fn_id;
    logic [15:0] ts;
    logic [31:0] arg;
  } task_t;

  // One outstanding enqueue: who asked, and whether the task queue was
  // already known full at acceptance (answered locally, never forwarded).
  typedef struct packed {
    tsb_entry_id_t tsb_id;
    logic          local_nack;
  } pend_entry_t;

  localparam int STAT_W = 32;

  // Occupancy counter width for a FIFO of the given depth.
  function automatic int pend_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tq_enq_responder_pend_fifo.sv
// In-order pending FIFO for tq_enq_responder. Push is accepted when not
// full or when a pop happens in the same cycle; head is the oldest entry.
module pend_fifo
  import tq_enq_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pend_entry_t push_entry,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output pend_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = pend_cnt_w(DEPTH);

  pend_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  // Qualify push/pop against occupancy; push at full needs a concurrent pop.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    head    = mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/tq_enq_responder.sv
// Task-queue enqueue responder: forwards TSB enqueue requests to the task
// queue, answers locally when the queue is known full, and returns one
// in-order response per accepted request.
// Optional feature macro: TQ_ENQ_STATS_EN enables saturating ack/nack counters.
module tq_enq_responder
  import tq_enq_responder_pkg::*;
#(
  parameter int PEND_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                task_enq_valid,
  output logic                task_enq_ready,
  input  task_t               task_enq_data,
  input  logic                task_enq_tied,
  input  tsb_entry_id_t       task_enq_tsb_id,
  input  logic                tq_full,
  output logic                tq_enq_valid,
  input  logic                tq_enq_ready,
  output task_t               tq_enq_data,
  output logic                tq_enq_tied,
  input  logic                tq_resp_valid,
  output logic                tq_resp_ready,
  input  logic                tq_resp_accept,
  input  epoch_t              tq_resp_epoch,
  input  tq_slot_t            tq_resp_slot,
  output logic                task_resp_valid,
  input  logic                task_resp_ready,
  output logic                task_resp_ack,
  output tsb_entry_id_t       task_resp_tsb_id,
  output epoch_t              task_resp_epoch,
  output tq_slot_t            task_resp_tq_slot,
  output logic [STAT_W-1:0]   stat_n_ack,
  output logic [STAT_W-1:0]   stat_n_nack,
  output logic                empty
);

  pend_entry_t pend_head;
  pend_entry_t push_entry;
  logic        pend_full;
  logic        pend_empty;
  logic        pend_push;
  logic        pend_pop;
  logic        head_valid;
  logic        out_free;
  logic        local_pop;
  logic        resp_fire;
  logic        enq_fire;

  pend_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pend_push),
    .push_entry (push_entry),
    .pop        (pend_pop),
    .full       (pend_full),
    .empty      (pend_empty),
    .head       (pend_head)
  );

  // Handshake decode: the head either self-retires (local nack) or waits
  // for the task queue's outcome; both need the output stage free.
  always_comb begin
    head_valid     = ~pend_empty;
    out_free       = ~task_resp_valid | task_resp_ready;
    local_pop      = ~rst & head_valid & pend_head.local_nack & out_free;
    tq_resp_ready  = ~rst & head_valid & ~pend_head.local_nack & out_free;
    resp_fire      = tq_resp_valid & tq_resp_ready;
    pend_pop       = local_pop | resp_fire;
    task_enq_ready = ~rst & ~(pend_full & ~pend_pop) & (~tq_enq_valid | tq_enq_ready);
    enq_fire       = task_enq_valid & task_enq_ready;
    pend_push      = enq_fire;
    push_entry     = '{tsb_id: task_enq_tsb_id, local_nack: tq_full};
    empty          = rst | (pend_empty & ~tq_enq_valid & ~task_resp_valid);
  end

  // Forward stage toward the task queue; held until the queue takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tq_enq_valid <= 1'b0;
      tq_enq_data  <= '0;
      tq_enq_tied  <= 1'b0;
    end else if (enq_fire && !tq_full) begin
      tq_enq_valid <= 1'b1;
      tq_enq_data  <= task_enq_data;
      tq_enq_tied  <= task_enq_tied;
    end else if (tq_enq_ready) begin
      tq_enq_valid <= 1'b0;
    end
  end

  // Registered response stage toward the TSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      task_resp_valid   <= 1'b0;
      task_resp_ack     <= 1'b0;
      task_resp_tsb_id  <= '0;
      task_resp_epoch   <= '0;
      task_resp_tq_slot <= '0;
    end else if (local_pop) begin
      task_resp_valid   <= 1'b1;
      task_resp_ack     <= 1'b0;
      task_resp_tsb_id  <= pend_head.tsb_id;
      task_resp_epoch   <= '0;
      task_resp_tq_slot <= '0;
    end else if (resp_fire) begin
      task_resp_valid   <= 1'b1;
      task_resp_ack     <= tq_resp_accept;
      task_resp_tsb_id  <= pend_head.tsb_id;
      task_resp_epoch   <= tq_resp_epoch;
      task_resp_tq_slot <= tq_resp_slot;
    end else if (task_resp_ready) begin
      task_resp_valid   <= 1'b0;
    end
  end

`ifdef TQ_ENQ_STATS_EN
  // Saturating response counters, split by ack value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_n_ack  <= '0;
      stat_n_nack <= '0;
    end else if (task_resp_valid && task_resp_ready) begin
      if (task_resp_ack && (stat_n_ack != '1))
        stat_n_ack <= stat_n_ack + STAT_W'(1);
      if (!task_resp_ack && (stat_n_nack != '1))
        stat_n_nack <= stat_n_nack + STAT_W'(1);
    end
  end
`else
  assign stat_n_ack  = '0;
  assign stat_n_nack = '0;
`endif

`ifndef SYNTHESIS
  // A task-queue outcome with no forwarded request at the head is a
  // protocol error upstream; it is stalled and reported here.
  always @(posedge clk) begin
    if (!rst && tq_resp_valid)
      assert (head_valid && !pend_head.local_nack)
        else $warning("tq_enq_responder: tq_resp_valid with no forwarded request at FIFO head");
  end
`endif

endmodule

// File: doc/tq_enq_responder.md
TQ_ENQ_RESPONDER -- requirements
Module: tq_enq_responder

Interface
REQ-001 SHALL have parameter PEND_DEPTH, default 4 (power of two, 2..16): maximum enqueue requests awaiting a task response.
REQ-002 SHALL have these ports, one per line as name  direction  width  meaning:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- task_enq_valid / task_enq_ready  in / out  1 / 1  enqueue request handshake from the task-spill buffer (TSB).
- task_enq_data  in  task_t  task payload.
- task_enq_tied  in  1  tied flag.
- task_enq_tsb_id  in  tsb_entry_id_t  requesting TSB entry.
- tq_full  in  1  task queue has no free slot.
- tq_enq_valid / tq_enq_ready  out / in  1 / 1  handshake to the task queue.
- tq_enq_data  out  task_t  payload to the task queue.
- tq_enq_tied  out  1  tied flag to the task queue.
- tq_resp_valid / tq_resp_ready  in / out  1 / 1  task queue outcome handshake.
- tq_resp_accept  in  1  1 = slot allocated.
- tq_resp_epoch  in  epoch_t  epoch of the allocated slot.
- tq_resp_slot  in  tq_slot_t  allocated slot.
- task_resp_valid / task_resp_ready  out / in  1 / 1  response handshake to the TSB.
- task_resp_ack  out  1  1 = task accepted.
- task_resp_tsb_id  out  tsb_entry_id_t  echoed TSB entry.
- task_resp_epoch  out  epoch_t  response epoch.
- task_resp_tq_slot  out  tq_slot_t  response slot.
- stat_n_ack  out  32  count of ack responses.
- stat_n_nack  out  32  count of nack responses.
- empty  out  1  no request in flight, for termination detection.

Function
REQ-003 SHALL keep an in-order pending FIFO of PEND_DEPTH entries; each entry is {tsb_id, local_nack}.
REQ-004 SHALL drive task_enq_ready = !pend_full_or_popping & (!tq_enq_valid | tq_enq_ready); a push and a pop in the same cycle at full SHALL be allowed.
REQ-005 On an accepted request with tq_full=0, SHALL present tq_enq_valid with the payload and tied flag on the next cycle, and SHALL push {tsb_id, 0}.
REQ-006 On an accepted request with tq_full=1, SHALL NOT forward to the task queue and SHALL push {tsb_id, 1}.
REQ-007 tq_enq_valid and its payload SHALL hold stable until tq_enq_ready; valid SHALL drop the cycle after the handshake unless a new request was accepted.
REQ-008 Output stage SHALL be registered; it is free when !task_resp_valid | task_resp_ready.
REQ-009 FIFO head with local_nack=1 and output stage free SHALL pop and load the response: ack=0, epoch=0, tq_slot=0, tsb_id=head.
REQ-010 tq_resp_ready = head valid & head.local_nack=0 & output stage free; on that handshake SHALL pop and load ack=tq_resp_accept, epoch=tq_resp_epoch, tq_slot=tq_resp_slot, tsb_id=head.
REQ-011 Latency SHALL be: enqueue handshake to tq_enq_valid, 1 cycle; tq_resp handshake to task_resp_valid, 1 cycle; local nack into an empty FIFO to task_resp_valid, 2 cycles.
REQ-012 tq_resp_valid while the FIFO is empty or the head is a local nack SHALL be stalled (ready low) and flagged by a simulation-only assertion.
REQ-013 Responses SHALL appear in request-acceptance order; every accepted request SHALL yield exactly one response.
REQ-014 empty SHALL be 1 when the FIFO, tq_enq_valid and task_resp_valid are all clear.
REQ-015 FIFO pointers SHALL wrap modulo PEND_DEPTH; the count SHALL be LOG2(PEND_DEPTH)+1 bits wide.

Reset
REQ-016 While rst=1 the block SHALL hold: FIFO empty, tq_enq_valid=0, task_resp_valid=0, stats=0, empty=1, task_enq_ready=0, tq_resp_ready=0.
REQ-017 Reset mid-operation SHALL discard in-flight entries without emitting responses.

Configuration
REQ-018 With TQ_ENQ_STATS_EN defined, stat_n_ack and stat_n_nack SHALL increment by one on each task_resp handshake, by ack value, saturating at all-ones.
REQ-019 Without TQ_ENQ_STATS_EN, both stat outputs SHALL be constant 0 and no counter logic SHALL be instantiated.

Structure
REQ-020 task_t, tsb_entry_id_t, epoch_t and tq_slot_t SHALL come from the shared swarm package; PEND_DEPTH stays local.
REQ-021 The pending FIFO SHALL be a sub-module named pend_fifo (push/pop/full/empty/head).

Verification
REQ-022 A bench SHALL cover these scenarios:
- tsb_id=5, tq_full=0, TQ accepts with epoch=3, slot=7 -> response ack=1, tsb_id=5, epoch=3, slot=7, one cycle after the tq_resp handshake.
- tsb_id=2 with tq_full=1 -> no tq_enq_valid; response ack=0, tsb_id=2, 2 cycles after the request.
- Requests 1 (forwarded), 2 (local nack), 3 (forwarded); TQ responds late -> responses in order 1, 2, 3; 2 is held behind 1.
- task_resp_ready=0 with 4 requests accepted -> task_enq_ready=0 at the 5th; after ready rises, all 4 responses drain and empty=1.
- Spurious tq_resp_valid with the FIFO empty -> tq_resp_ready=0 and the assertion fires.
- rst pulsed with 3 requests in flight -> all valids 0 next cycle, empty=1, no responses; with TQ_ENQ_STATS_EN, stats return to 0.
